// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the arithmetic unit: one instruction per handshake,
// accumulator feedback, latency wait, result return. Optional flags: ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
    parameter int DATA_W     = 4,
    parameter int ADDSUB_LAT = 1,
    parameter int SHIFT_LAT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_opcode,
    input  logic [DATA_W-1:0] instr_operand,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_lshift,
    output logic              alu_rshift,
    output logic              alu_load_en,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              err_illegal
`ifdef ALU_SEQ_FLAGS_EN
   ,output logic              res_zero,
    output logic              sticky_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_LSH  = 3'b011,
        OP_RSH  = 3'b100,
        OP_LOAD = 3'b101,
        OP_CLR  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    localparam int MAX_LAT = (ADDSUB_LAT > SHIFT_LAT) ? ADDSUB_LAT : SHIFT_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] ADDSUB_CNT = CNT_W'(ADDSUB_LAT - 1);
    localparam logic [CNT_W-1:0] SHIFT_CNT  = CNT_W'(SHIFT_LAT - 1);

    state_e            state_q, state_d;
    opcode_e           opc_q, opc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;
    logic              armed_q;
    logic              sticky_q, sticky_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opc_q    <= OP_NOP;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            armed_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            armed_q  <= 1'b1;
            sticky_q <= sticky_d;
        end
    end

    // armed_q keeps instr_ready low until the first edge after reset release
    assign instr_ready  = (state_q == IDLE) && armed_q;
    assign alu_in1      = acc_q;
    assign alu_in2      = opnd_q;
    assign res_valid    = (state_q == DONE);
    assign res_data     = acc_q;
    assign res_overflow = ovf_q;
    assign err_illegal  = ill_q;

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        sticky_d    = sticky_q;
        alu_add     = 1'b0;
        alu_sub     = 1'b0;
        alu_lshift  = 1'b0;
        alu_rshift  = 1'b0;
        alu_load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    opc_d  = opcode_e'(instr_opcode);
                    opnd_d = instr_operand;
                    ovf_d  = 1'b0;
                    case (opcode_e'(instr_opcode))
                        OP_ADD, OP_SUB: begin
                            state_d = EXEC;
                            cnt_d   = ADDSUB_CNT;
                        end
                        OP_LSH, OP_RSH: begin
                            state_d = EXEC;
                            cnt_d   = SHIFT_CNT;
                        end
                        OP_LOAD: begin
                            acc_d   = instr_operand;
                            state_d = DONE;
                        end
                        OP_CLR: begin
                            acc_d    = '0;
                            sticky_d = 1'b0;
                            state_d  = DONE;
                        end
                        OP_ILL: begin
                            ill_d   = 1'b1;
                            state_d = DONE;
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            EXEC: begin
                alu_add     = (opc_q == OP_ADD);
                alu_sub     = (opc_q == OP_SUB);
                alu_lshift  = (opc_q == OP_LSH);
                alu_rshift  = (opc_q == OP_RSH);
                // cnt only moves in EXEC, so its start value marks the first cycle
                alu_load_en = (alu_lshift || alu_rshift) && (cnt_q == SHIFT_CNT);
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    acc_d   = alu_out;
                    ovf_d   = alu_overflow;
                    state_d = DONE;
                    if (alu_overflow) sticky_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    ill_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    assign res_zero   = res_valid && (acc_q == '0);
    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a randomized
// back-to-back stream checked against an arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int DATA_W     = 4;
    localparam int ADDSUB_LAT = 1;
    localparam int SHIFT_LAT  = 3;
    localparam int MOD        = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic              alu_add, alu_sub, alu_lshift, alu_rshift, alu_load_en;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
    logic              alu_overflow;
    logic              res_valid, res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_overflow, err_illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic              res_zero, sticky_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] model_acc    = '0;
    logic              model_sticky = 1'b0;

    alu_op_sequencer #(
        .DATA_W    (DATA_W),
        .ADDSUB_LAT(ADDSUB_LAT),
        .SHIFT_LAT (SHIFT_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .alu_add      (alu_add),
        .alu_sub      (alu_sub),
        .alu_lshift   (alu_lshift),
        .alu_rshift   (alu_rshift),
        .alu_load_en  (alu_load_en),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .err_illegal  (err_illegal)
`ifdef ALU_SEQ_FLAGS_EN
       ,.res_zero     (res_zero),
        .sticky_ovf   (sticky_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic any_strobe;
    assign any_strobe = alu_add | alu_sub | alu_lshift | alu_rshift;

    // Arithmetic unit stand-in: the result is only correct in the strobe cycle
    // where the latency has elapsed; earlier cycles present inverted garbage.
    int exec_k;
    always @(posedge clk or posedge reset) begin
        if (reset)           exec_k <= 0;
        else if (any_strobe) exec_k <= exec_k + 1;
        else                 exec_k <= 0;
    end

    always @* begin
        int s;
        int lat;
        logic [DATA_W-1:0] r;
        logic f;
        s = 0; lat = 1; r = '0; f = 1'b0;
        if (alu_add) begin
            s = int'(alu_in1) + int'(alu_in2);
            r = DATA_W'(s % MOD); f = (s >= MOD); lat = ADDSUB_LAT;
        end else if (alu_sub) begin
            s = int'(alu_in1) - int'(alu_in2) + MOD;
            r = DATA_W'(s % MOD); f = (alu_in1 < alu_in2); lat = ADDSUB_LAT;
        end else if (alu_lshift) begin
            s = int'(alu_in1) * 2;
            r = DATA_W'(s % MOD); f = (s >= MOD); lat = SHIFT_LAT;
        end else if (alu_rshift) begin
            s = int'(alu_in1) / 2;
            r = DATA_W'(s); f = ((int'(alu_in1) % 2) == 1); lat = SHIFT_LAT;
        end
        if (exec_k == lat - 1) begin
            alu_out = r; alu_overflow = f;
        end else begin
            alu_out = ~r; alu_overflow = ~f;
        end
    end

    // Strobe activity monitor, read by the test tasks as deltas.
    int add_c = 0, sub_c = 0, lsh_c = 0, rsh_c = 0;
    int load_c = 0, load_first_c = 0, load_out_c = 0, multi_c = 0, unstable_c = 0;
    logic prev_any = 1'b0;
    logic [DATA_W-1:0] prev_in1 = '0, prev_in2 = '0, first_in1 = '0, first_in2 = '0;

    always @(negedge clk) begin
        if (alu_add)    add_c <= add_c + 1;
        if (alu_sub)    sub_c <= sub_c + 1;
        if (alu_lshift) lsh_c <= lsh_c + 1;
        if (alu_rshift) rsh_c <= rsh_c + 1;
        if (int'(alu_add) + int'(alu_sub) + int'(alu_lshift) + int'(alu_rshift) > 1)
            multi_c <= multi_c + 1;
        if (any_strobe) begin
            if (alu_load_en) begin
                load_c <= load_c + 1;
                if (!prev_any) load_first_c <= load_first_c + 1;
            end
            if (!prev_any) begin
                first_in1 <= alu_in1;
                first_in2 <= alu_in2;
            end else if (alu_in1 != prev_in1 || alu_in2 != prev_in2) begin
                unstable_c <= unstable_c + 1;
            end
        end else if (alu_load_en) begin
            load_out_c <= load_out_c + 1;
        end
        prev_any <= any_strobe;
        prev_in1 <= alu_in1;
        prev_in2 <= alu_in2;
    end

    function automatic void model_step(input logic [2:0] op, input logic [DATA_W-1:0] v,
                                       output logic [DATA_W-1:0] d, output logic o,
                                       output logic il, output int lat);
        int a;
        int r;
        a = int'(model_acc);
        r = a; o = 1'b0; il = 1'b0; lat = 0;
        case (op)
            3'd1: begin r = a + int'(v); o = (r >= MOD); lat = ADDSUB_LAT; end
            3'd2: begin r = a - int'(v) + MOD; o = (a < int'(v)); lat = ADDSUB_LAT; end
            3'd3: begin r = a * 2; o = (r >= MOD); lat = SHIFT_LAT; end
            3'd4: begin r = a / 2; o = ((a % 2) == 1); lat = SHIFT_LAT; end
            3'd5: r = int'(v);
            3'd6: r = 0;
            3'd7: il = 1'b1;
            default: r = a;
        endcase
        model_acc = DATA_W'(r % MOD);
        if (o) model_sticky = 1'b1;
        if (op == 3'd6) model_sticky = 1'b0;
        d = model_acc;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [DATA_W-1:0] v,
                         output logic [DATA_W-1:0] d, output logic o, output logic il);
        int n;
        bit got;
        logic [DATA_W-1:0] md;
        logic mo, mil;
        int mlat;
        d = '0; o = 1'b0; il = 1'b0;
        instr_opcode = op; instr_operand = v; instr_valid = 1'b1;
        got = 0; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (instr_ready) got = 1;
            n++;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout op=%0d instr_ready=%b required=1", op, instr_ready);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        model_step(op, v, md, mo, mil, mlat);
        got = 0; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1; d = res_data; o = res_overflow; il = err_illegal;
            end
            n++;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL result_timeout op=%0d res_valid=%b required=1", op, res_valid);
        end else if (res_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({instr_ready, alu_add, alu_sub, alu_lshift, alu_rshift, alu_load_en,
             res_valid, res_overflow, err_illegal} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0", {instr_ready, alu_add, alu_sub,
                     alu_lshift, alu_rshift, alu_load_en, res_valid, res_overflow, err_illegal});
        end
        checks++;
        if ({alu_in1, alu_in2, res_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h required=0", {alu_in1, alu_in2, res_data});
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_ready got=%b required=0", instr_ready);
        end
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            failures++;
            $display("FAIL release_ready_early got=%b required=0", instr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got=%b required=1", instr_ready);
        end
    endtask

    task automatic test_load_add();
        logic [DATA_W-1:0] d;
        logic o, il;
        int a0, o0;
        do_op(3'd5, 4'h7, d, o, il);
        checks++;
        if (d !== 4'h7) begin failures++; $display("FAIL load_data got=%h required=7", d); end
        a0 = add_c; o0 = sub_c + lsh_c + rsh_c + load_c;
        do_op(3'd1, 4'h3, d, o, il);
        checks++;
        if (add_c - a0 != 1 || sub_c + lsh_c + rsh_c + load_c - o0 != 0) begin
            failures++;
            $display("FAIL add_strobe add_cycles=%0d others=%0d required 1/0",
                     add_c - a0, sub_c + lsh_c + rsh_c + load_c - o0);
        end
        checks++;
        if (first_in1 !== 4'h7 || first_in2 !== 4'h3) begin
            failures++;
            $display("FAIL add_operands in1=%h in2=%h required 7/3", first_in1, first_in2);
        end
        checks++;
        if (d !== 4'hA || o !== 1'b0 || il !== 1'b0) begin
            failures++;
            $display("FAIL add_result data=%h ovf=%b ill=%b required a/0/0", d, o, il);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] d;
        logic o, il;
        do_op(3'd5, 4'h2, d, o, il);
        do_op(3'd1, 4'hF, d, o, il);
        checks++;
        if (d !== 4'h1 || o !== 1'b1) begin
            failures++;
            $display("FAIL add_overflow data=%h ovf=%b required 1/1", d, o);
        end
`ifdef ALU_SEQ_FLAGS_EN
        do_op(3'd0, 4'h0, d, o, il);
        checks++;
        if (sticky_ovf !== 1'b1 || o !== 1'b0) begin
            failures++;
            $display("FAIL sticky_hold sticky=%b ovf=%b required 1/0", sticky_ovf, o);
        end
        do_op(3'd6, 4'h0, d, o, il);
        checks++;
        if (sticky_ovf !== 1'b0 || d !== 4'h0) begin
            failures++;
            $display("FAIL sticky_clr sticky=%b data=%h required 0/0", sticky_ovf, d);
        end
`endif
    endtask

    task automatic test_rsh();
        logic [DATA_W-1:0] d;
        logic o, il;
        int r0, l0, f0, x0;
        do_op(3'd5, 4'h8, d, o, il);
        r0 = rsh_c; l0 = load_c; f0 = load_first_c; x0 = add_c + sub_c + lsh_c;
        do_op(3'd4, 4'h0, d, o, il);
        checks++;
        if (rsh_c - r0 != SHIFT_LAT || add_c + sub_c + lsh_c - x0 != 0) begin
            failures++;
            $display("FAIL rsh_strobe cycles=%0d others=%0d required %0d/0",
                     rsh_c - r0, add_c + sub_c + lsh_c - x0, SHIFT_LAT);
        end
        checks++;
        if (load_c - l0 != 1 || load_first_c - f0 != 1) begin
            failures++;
            $display("FAIL rsh_load_en total=%0d first=%0d required 1/1",
                     load_c - l0, load_first_c - f0);
        end
        checks++;
        if (d !== 4'h4 || o !== 1'b0) begin
            failures++;
            $display("FAIL rsh_result data=%h ovf=%b required 4/0", d, o);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d;
        logic o, il;
        do_op(3'd5, 4'h6, d, o, il);
        res_ready = 1'b0;
        do_op(3'd1, 4'h1, d, o, il);
        checks++;
        if (d !== 4'h7) begin failures++; $display("FAIL bp_first data=%h required 7", d); end
        instr_opcode = 3'd5; instr_operand = 4'hF; instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 4'h7 || instr_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%b data=%h ready=%b required 1/7/0",
                         i, res_valid, res_data, instr_ready);
            end
        end
        instr_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release valid=%b ready=%b required 0/1", res_valid, instr_ready);
        end
        do_op(3'd0, 4'h0, d, o, il);
        checks++;
        if (d !== 4'h7) begin failures++; $display("FAIL bp_no_accept data=%h required 7", d); end
    endtask

    task automatic test_illegal();
        logic [DATA_W-1:0] d;
        logic o, il;
        int s0;
        do_op(3'd5, 4'h5, d, o, il);
        s0 = add_c + sub_c + lsh_c + rsh_c + load_c;
        do_op(3'd7, 4'h9, d, o, il);
        checks++;
        if (il !== 1'b1 || d !== 4'h5 || o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_result ill=%b data=%h ovf=%b required 1/5/0", il, d, o);
        end
        checks++;
        if (add_c + sub_c + lsh_c + rsh_c + load_c - s0 != 0) begin
            failures++;
            $display("FAIL illegal_strobe cycles=%0d required 0",
                     add_c + sub_c + lsh_c + rsh_c + load_c - s0);
        end
        checks++;
        if (err_illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear got=%b required 0", err_illegal);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [DATA_W-1:0] d;
        logic o, il;
        int n;
        do_op(3'd5, 4'h5, d, o, il);
        instr_opcode = 3'd1; instr_operand = 4'h2; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if (alu_add !== 1'b1) begin failures++; $display("FAIL mid_exec_add got=%b required 1", alu_add); end
        #2 reset = 1'b1;
        #1;
        model_acc = '0; model_sticky = 1'b0;
        checks++;
        if ({instr_ready, alu_add, alu_sub, alu_lshift, alu_rshift, alu_load_en,
             res_valid, res_overflow, err_illegal} !== 9'b0 ||
            {alu_in1, alu_in2, res_data} !== '0) begin
            failures++;
            $display("FAIL mid_exec_abort ctrl=%b data=%h required 0/0", {instr_ready, alu_add,
                     alu_sub, alu_lshift, alu_rshift, alu_load_en, res_valid, res_overflow,
                     err_illegal}, {alu_in1, alu_in2, res_data});
        end
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (instr_ready !== 1'b0) begin failures++; $display("FAIL mid_exec_ready_early got=%b required 0", instr_ready); end
        @(posedge clk); #1;
        checks++;
        if (instr_ready !== 1'b1 || res_data !== 4'h0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_exec_recover ready=%b acc=%h valid=%b required 1/0/0",
                     instr_ready, res_data, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d[$];
        logic exp_o[$], exp_il[$], exp_st[$];
        logic [DATA_W-1:0] md, ed;
        logic mo, mil, eo, eil, est;
        int mlat, n_acc, last_acc, last_gap, budget;
        logic [2:0] op;
        logic [DATA_W-1:0] v;
        n_acc = 0; last_acc = 0; last_gap = 0; budget = 0;
        res_ready = 1'b1;
        op = 3'($urandom_range(0, 7)); v = DATA_W'($urandom);
        instr_opcode = op; instr_operand = v; instr_valid = 1'b1;
        while ((n_acc < 40 || exp_d.size() > 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (res_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected data=%h required no result", res_data);
                end else begin
                    ed = exp_d.pop_front(); eo = exp_o.pop_front();
                    eil = exp_il.pop_front(); est = exp_st.pop_front();
                    if (res_data !== ed || res_overflow !== eo || err_illegal !== eil) begin
                        failures++;
                        $display("FAIL b2b_result data=%h ovf=%b ill=%b required %h/%b/%b",
                                 res_data, res_overflow, err_illegal, ed, eo, eil);
                    end
`ifdef ALU_SEQ_FLAGS_EN
                    checks++;
                    if (sticky_ovf !== est || res_zero !== (ed == '0)) begin
                        failures++;
                        $display("FAIL b2b_flags sticky=%b zero=%b required %b/%b",
                                 sticky_ovf, res_zero, est, (ed == '0));
                    end
`endif
                end
            end
            if (instr_valid && instr_ready) begin
                model_step(op, v, md, mo, mil, mlat);
                exp_d.push_back(md); exp_o.push_back(mo);
                exp_il.push_back(mil); exp_st.push_back(model_sticky);
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != last_gap) begin
                        failures++;
                        $display("FAIL b2b_throughput gap=%0d required %0d", cyc - last_acc, last_gap);
                    end
                end
                last_acc = cyc; last_gap = mlat + 2;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < 40) begin
                    op = 3'($urandom_range(0, 7)); v = DATA_W'($urandom);
                    instr_opcode = op; instr_operand = v;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (budget >= 2000) begin
            failures++;
            $display("FAIL b2b_timeout accepted=%0d pending=%0d required 40/0", n_acc, exp_d.size());
        end
        checks++;
        if (multi_c != 0 || load_out_c != 0 || unstable_c != 0) begin
            failures++;
            $display("FAIL strobe_rules multi=%0d load_outside=%0d unstable=%0d required 0/0/0",
                     multi_c, load_out_c, unstable_c);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr_opcode = 3'd0;
        instr_operand = '0;
        res_ready = 1'b1;
        test_reset();
        test_load_add();
        test_overflow();
        test_rsh();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
